// File: rtl/rcg_ctrl_rcc_seq.sv
// rcg_ctrl_rcc_seq: power-up / power-down sequencer for a bank of RCC channels.
// A start request walks the channels upward with the enable command. A stop
// request walks them downward with the disable command. For each participating
// channel the block issues one strobe, waits for the channel to echo the
// command, then idles for a programmable gap before moving to the next channel.
module rcg_ctrl_rcc_seq #(
  parameter int NUM_MOD = 8,
  parameter int DLY_W   = 8,
  parameter int IDX_W   = $clog2(NUM_MOD)
) (
  input  logic                   rcg_ctrl_rf_clk,
  input  logic                   grst,
  input  logic                   seq_start,
  input  logic                   seq_stop,
  input  logic [NUM_MOD-1:0]     seq_mask,
  input  logic [DLY_W-1:0]       seq_gap_dly,
  input  logic [DLY_W-1:0]       seq_ack_tmo,
  input  logic                   seq_err_clr,
  input  logic [6*NUM_MOD-1:0]   rcc_rf_state_out,
  output logic [NUM_MOD-1:0]     rcc_rf_stb,
  output logic [2:0]             rcc_rf_state_in,
  output logic                   seq_busy,
  output logic                   seq_done,
  output logic                   seq_err,
  output logic [IDX_W-1:0]       seq_err_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_GAP,
    S_FINISH
  } state_e;

  localparam logic [2:0]       CMD_IDLE = 3'd0;
  localparam logic [2:0]       CMD_EN   = 3'd1;
  localparam logic [2:0]       CMD_DIS  = 3'd2;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_MOD - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);
  localparam logic [DLY_W-1:0] DLY_MAX  = {DLY_W{1'b1}};

  state_e             state_q, state_d;
  logic [2:0]         cmd_q, cmd_d;
  logic               down_q, down_d;
  logic [NUM_MOD-1:0] mask_q, mask_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DLY_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [DLY_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   err_idx_q, err_idx_d;

  logic [2:0]         ch_state;
  logic               ack;
  logic               tmo_hit;
  logic               last_ch;
  logic               err_set;
  logic [IDX_W-1:0]   idx_next;

  // Current state field of the channel being sequenced; upper status bits are not used here.
  assign ch_state = rcc_rf_state_out[6*int'(idx_q) +: 3];
  assign ack      = (ch_state == cmd_q);
  // A zero timeout disables the check entirely.
  assign tmo_hit  = (seq_ack_tmo != '0) && (tmo_cnt_q == seq_ack_tmo - DLY_ONE);
  assign last_ch  = down_q ? (idx_q == '0) : (idx_q == IDX_LAST);
  // Only consumed when last_ch is low, so idx never leaves the channel range.
  assign idx_next = down_q ? (idx_q - IDX_ONE) : (idx_q + IDX_ONE);

  // Next-state, counter and strobe logic for the channel walk.
  always_comb begin
    // NOTE: every signal written in this block gets a default first so no latch is inferred.
    state_d    = state_q;
    cmd_d      = cmd_q;
    down_d     = down_q;
    mask_d     = mask_q;
    idx_d      = idx_q;
    tmo_cnt_d  = tmo_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    err_set    = 1'b0;
    rcc_rf_stb = '0;
    seq_done   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (seq_start || seq_stop) begin
          // Stop wins when both requests arrive together.
          cmd_d   = seq_stop ? CMD_DIS : CMD_EN;
          down_d  = seq_stop;
          mask_d  = seq_mask;
          idx_d   = seq_stop ? IDX_LAST : '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mask_q[idx_q]) begin
          rcc_rf_stb[idx_q] = 1'b1;
          tmo_cnt_d         = '0;
          state_d           = S_WAIT_ACK;
        end else if (last_ch) begin
          state_d = S_FINISH;
        end else begin
          idx_d = idx_next;
        end
      end
      S_WAIT_ACK: begin
        // Ack has priority over a timeout expiring in the same cycle.
        if (ack) begin
          gap_cnt_d = seq_gap_dly;
          state_d   = S_GAP;
        end else if (tmo_hit) begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end else if (tmo_cnt_q != DLY_MAX) begin
          tmo_cnt_d = tmo_cnt_q + DLY_ONE;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          if (last_ch) begin
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_next;
            state_d = S_ISSUE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - DLY_ONE;
        end
      end
      S_FINISH: begin
        seq_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sticky error flag: a new timeout outranks a clear in the same cycle.
  always_comb begin
    err_d     = err_q;
    err_idx_d = err_idx_q;
    if (err_set) begin
      err_d     = 1'b1;
      err_idx_d = idx_q;
    end else if (seq_err_clr) begin
      err_d     = 1'b0;
      err_idx_d = '0;
    end
  end

  // State register with synchronous reset; reset drops any sequence in flight.
  always_ff @(posedge rcg_ctrl_rf_clk) begin
    // NOTE: non-blocking assignments so every flop samples its pre-edge inputs together.
    if (grst) begin
      state_q   <= S_IDLE;
      cmd_q     <= CMD_IDLE;
      down_q    <= 1'b0;
      mask_q    <= '0;
      idx_q     <= '0;
      tmo_cnt_q <= '0;
      gap_cnt_q <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      down_q    <= down_d;
      mask_q    <= mask_d;
      idx_q     <= idx_d;
      tmo_cnt_q <= tmo_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end

  // Busy covers the walk itself; the done cycle and idle report not busy.
  assign seq_busy        = (state_q == S_ISSUE) || (state_q == S_WAIT_ACK) || (state_q == S_GAP);
  assign rcc_rf_state_in = seq_busy ? cmd_q : CMD_IDLE;
  assign seq_err         = err_q;
  assign seq_err_idx     = err_idx_q;

endmodule

// File: tb/tb_rcg_ctrl_rcc_seq.sv
// Testbench for rcg_ctrl_rcc_seq. The stimulus side computes the whole expected
// event timeline of a sequence (strobes, done, error) from the sequencing rules
// and queues it. A monitor pops and compares whenever the DUT strobes, finishes
// or raises an error. A small channel model echoes the command after a
// per-channel delay (0 = never).
module tb_rcg_ctrl_rcc_seq;

  localparam int NUM_MOD = 4;
  localparam int DLY_W   = 8;
  localparam int IDX_W   = 2;

  typedef enum int {EV_STB, EV_DONE, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       cyc;
    int       ch;
  } ev_t;

  logic                 clk;
  logic                 grst;
  logic                 seq_start;
  logic                 seq_stop;
  logic [NUM_MOD-1:0]   seq_mask;
  logic [DLY_W-1:0]     seq_gap_dly;
  logic [DLY_W-1:0]     seq_ack_tmo;
  logic                 seq_err_clr;
  logic [6*NUM_MOD-1:0] rcc_rf_state_out;
  logic [NUM_MOD-1:0]   rcc_rf_stb;
  logic [2:0]           rcc_rf_state_in;
  logic                 seq_busy;
  logic                 seq_done;
  logic                 seq_err;
  logic [IDX_W-1:0]     seq_err_idx;

  int         n_cmp;
  int         n_fail;
  int         cyc;
  ev_t        exp_q[$];
  logic [2:0] exp_cmd;
  int         ack_dly [NUM_MOD];
  bit         err_prev;

  rcg_ctrl_rcc_seq #(.NUM_MOD(NUM_MOD), .DLY_W(DLY_W)) dut (
    .rcg_ctrl_rf_clk  (clk),
    .grst             (grst),
    .seq_start        (seq_start),
    .seq_stop         (seq_stop),
    .seq_mask         (seq_mask),
    .seq_gap_dly      (seq_gap_dly),
    .seq_ack_tmo      (seq_ack_tmo),
    .seq_err_clr      (seq_err_clr),
    .rcc_rf_state_out (rcc_rf_state_out),
    .rcc_rf_stb       (rcc_rf_stb),
    .rcc_rf_state_in  (rcc_rf_state_in),
    .seq_busy         (seq_busy),
    .seq_done         (seq_done),
    .seq_err          (seq_err),
    .seq_err_idx      (seq_err_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle number; sampled at the falling edge it names the current cycle.
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_event(input ev_kind_e kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_event: got %s at cycle %0d expected no event", kind.name(), cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_cycle", cyc, e.cyc);
      if (kind == EV_STB) check("stb_vec", rcc_rf_stb, longint'(1) << e.ch);
      if (kind == EV_ERR) check("err_idx", seq_err_idx, e.ch);
    end
  endtask

  // Monitor: compares every DUT event against the head of the expected queue.
  initial begin
    err_prev = 1'b0;
    forever begin
      @(negedge clk);
      check("state_in", rcc_rf_state_in, seq_busy ? exp_cmd : 3'd0);
      if (rcc_rf_stb != '0) expect_event(EV_STB);
      if (seq_done) expect_event(EV_DONE);
      if (seq_err && !err_prev) expect_event(EV_ERR);
      err_prev = seq_err;
    end
  end

  // Channel model: on a strobe the status goes transitional (4), then shows
  // the command ack_dly cycles later, where the sequencer samples it.
  initial begin
    logic [2:0] st   [NUM_MOD];
    logic [2:0] pend [NUM_MOD];
    int         cnt  [NUM_MOD];
    for (int i = 0; i < NUM_MOD; i++) begin
      st[i] = 3'd0; pend[i] = 3'd0; cnt[i] = 0;
    end
    rcc_rf_state_out = '0;
    forever begin
      @(negedge clk);
      if (grst) begin
        for (int i = 0; i < NUM_MOD; i++) begin
          st[i] = 3'd0; cnt[i] = 0;
        end
      end else begin
        for (int i = 0; i < NUM_MOD; i++) begin
          if (cnt[i] > 0) begin
            cnt[i]--;
            if (cnt[i] == 0) st[i] = pend[i];
          end
        end
        for (int i = 0; i < NUM_MOD; i++) begin
          if (rcc_rf_stb[i]) begin
            st[i]   = 3'd4;
            cnt[i]  = ack_dly[i];
            pend[i] = rcc_rf_state_in;
          end
        end
      end
      // Upper status bits carry a constant pattern that must be ignored.
      for (int i = 0; i < NUM_MOD; i++) rcc_rf_state_out[6*i +: 6] = {3'b101, st[i]};
    end
  end

  // Issue a request and queue the full expected timeline. Cycle c walks the
  // channel order: a skipped channel costs one cycle; a strobed channel that
  // acks after k cycles costs k + gap + 2 cycles; a timeout after tmo waiting
  // cycles registers the error flag one cycle later and ends the walk.
  task automatic issue(input bit start, input bit stop, input logic [NUM_MOD-1:0] mask,
                       input int gap, input int tmo);
    int c;
    bit aborted;
    @(negedge clk);
    seq_mask    = mask;
    seq_gap_dly = DLY_W'(gap);
    seq_ack_tmo = DLY_W'(tmo);
    seq_start   = start;
    seq_stop    = stop;
    exp_cmd     = stop ? 3'd2 : 3'd1;
    c       = cyc + 1;
    aborted = 1'b0;
    for (int j = 0; j < NUM_MOD && !aborted; j++) begin
      int ch;
      ch = stop ? NUM_MOD - 1 - j : j;
      if (!mask[ch]) begin
        c = c + 1;
      end else begin
        exp_q.push_back('{EV_STB, c, ch});
        if (tmo != 0 && (ack_dly[ch] == 0 || ack_dly[ch] > tmo)) begin
          exp_q.push_back('{EV_ERR, c + tmo + 1, ch});
          aborted = 1'b1;
        end else begin
          c = c + ack_dly[ch] + gap + 2;
        end
      end
    end
    if (!aborted) exp_q.push_back('{EV_DONE, c, 0});
    @(negedge clk);
    seq_start = 1'b0;
    seq_stop  = 1'b0;
    // The mask was latched with the request; changing it now must not matter.
    seq_mask  = NUM_MOD'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!seq_busy && exp_q.size() == 0) break;
    end
    check("seq_drained", exp_q.size(), 0);
    check("idle_busy", seq_busy, 0);
    exp_q.delete();
  endtask

  // A request while busy must be ignored.
  task automatic pulse_if_busy(input bit use_stop);
    @(negedge clk);
    if (seq_busy) begin
      if (use_stop) seq_stop = 1'b1;
      else seq_start = 1'b1;
      @(negedge clk);
      seq_start = 1'b0;
      seq_stop  = 1'b0;
    end
  endtask

  task automatic clear_err();
    @(negedge clk);
    seq_err_clr = 1'b1;
    @(negedge clk);
    seq_err_clr = 1'b0;
    check("err_cleared", seq_err, 0);
    check("err_idx_cleared", seq_err_idx, 0);
  endtask

  initial begin
    bit found;
    int tmo;
    int mode;
    n_cmp = 0; n_fail = 0; cyc = 0;
    grst = 1'b1; seq_start = 1'b0; seq_stop = 1'b0; seq_mask = '0;
    seq_gap_dly = '0; seq_ack_tmo = '0; seq_err_clr = 1'b0; exp_cmd = 3'd0;
    ack_dly = '{1, 1, 1, 1};
    repeat (3) @(negedge clk);
    check("rst_stb", rcc_rf_stb, 0);
    check("rst_state_in", rcc_rf_state_in, 0);
    check("rst_busy", seq_busy, 0);
    check("rst_done", seq_done, 0);
    check("rst_err", seq_err, 0);
    check("rst_err_idx", seq_err_idx, 0);
    grst = 1'b0;

    // Power-up over all channels, ack 3 cycles after each strobe, gap 2.
    ack_dly = '{3, 3, 3, 3};
    issue(1'b1, 1'b0, 4'b1111, 2, 0);
    wait_idle(200);

    // Power-down over channels 3 and 1 only.
    issue(1'b0, 1'b1, 4'b1010, 2, 0);
    wait_idle(200);

    // Channel 2 never acks; clear held high must lose to the error set.
    ack_dly = '{2, 3, 0, 1};
    seq_err_clr = 1'b1;
    issue(1'b1, 1'b0, 4'b1111, 1, 5);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (seq_err) begin
        found = 1'b1;
        seq_err_clr = 1'b0;
      end
    end
    seq_err_clr = 1'b0;
    check("err_raised", found, 1);
    wait_idle(50);

    // Start and stop together while the error is still set; extra start mid-walk.
    ack_dly = '{2, 2, 2, 2};
    issue(1'b1, 1'b1, 4'b1111, 1, 0);
    repeat (5) @(negedge clk);
    pulse_if_busy(1'b0);
    wait_idle(200);
    check("err_sticky", seq_err, 1);
    check("err_idx_sticky", seq_err_idx, 2);
    clear_err();

    // Reset while waiting for channel 1's ack, then restart from channel 0.
    ack_dly = '{3, 4, 3, 3};
    issue(1'b1, 1'b0, 4'b1111, 1, 0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (rcc_rf_stb[1]) found = 1'b1;
    end
    check("reach_ch1", found, 1);
    @(negedge clk);
    grst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    grst = 1'b0;
    exp_q.delete();
    check("midrst_stb", rcc_rf_stb, 0);
    check("midrst_busy", seq_busy, 0);
    check("midrst_state_in", rcc_rf_state_in, 0);
    check("midrst_done", seq_done, 0);
    ack_dly = '{1, 2, 1, 2};
    issue(1'b1, 1'b0, 4'b1111, 0, 0);
    wait_idle(200);

    // Empty mask: one cycle per channel, then done.
    issue(1'b1, 1'b0, 4'b0000, 0, 0);
    wait_idle(50);

    // Ack arrives in the very cycle the timeout would expire: no error.
    ack_dly = '{3, 3, 3, 3};
    issue(1'b0, 1'b1, 4'b1111, 0, 3);
    wait_idle(200);
    check("ack_beats_tmo", seq_err, 0);

    // Randomized sequences against the timeline model.
    for (int it = 0; it < 40; it++) begin
      if (seq_err) clear_err();
      tmo = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0;
      for (int ch = 0; ch < NUM_MOD; ch++)
        ack_dly[ch] = (tmo != 0 && $urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 7));
      mode = int'($urandom_range(0, 2));
      issue(mode != 1, mode != 0, NUM_MOD'($urandom), int'($urandom_range(0, 3)), tmo);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 5)) @(negedge clk);
        pulse_if_busy($urandom_range(0, 1) == 1);
      end
      wait_idle(400);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
